adder_operand_packer: RTL and testbench

//  Upstream feeder for the adder stage. Accepts a byte stream (valid/ready), assembles one operand record and presents it as the packed ins vector.
//  - Record: s1.{x,y,z,w}, s2.{x,y,z,w}, cin.
//  - Record output is held stable until the consumer takes it.
//  - Flags framing errors (early restart, missing start).

---
 rtl/adder_operand_packer_pkg.sv | 24 ++
 rtl/adder_operand_packer_if.sv | 34 +++
 rtl/adder_operand_packer.sv | 131 +++++++++++++
 tb/tb_adder_operand_packer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/adder_operand_packer_pkg.sv
// Shared definitions for the adder operand packer: default widths, record layout
// helpers and FSM state encoding.
package adder_operand_packer_pkg;

    localparam int FIELD_W_DEF  = 8;
    localparam int N_FIELDS_DEF = 4;
    localparam int ERR_W_DEF    = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2
    } pack_state_t;

    function automatic int ins_w(input int field_w, input int n_fields);
        return 2 * n_fields * field_w + 1;
    endfunction

    // s2 fields sit one bit higher than a plain concatenation to make room for cin
    function automatic int field_off(input int k, input int field_w, input int n_fields);
        return k * field_w + ((k >= n_fields) ? 1 : 0);
    endfunction

endpackage

// File: rtl/adder_operand_packer_if.sv
// Byte-stream input and packed-record output of the adder operand packer.
interface adder_operand_packer_if
    import adder_operand_packer_pkg::*;
#(
    parameter int FIELD_W  = FIELD_W_DEF,
    parameter int N_FIELDS = N_FIELDS_DEF,
    parameter int ERR_W    = ERR_W_DEF
) ();

    localparam int INS_W = ins_w(FIELD_W, N_FIELDS);

    logic [FIELD_W-1:0] in_data;
    logic               in_first;
    logic               in_cin;
    logic               in_valid;
    logic               in_ready;
    logic [INS_W-1:0]   ins;
    logic               ins_valid;
    logic               ins_ready;
    logic [ERR_W-1:0]   err_cnt;

    // master: producer of beats and consumer of records
    modport master (
        output in_data, in_first, in_cin, in_valid, ins_ready,
        input  in_ready, ins, ins_valid, err_cnt
    );

    // slave: the packer itself
    modport slave (
        input  in_data, in_first, in_cin, in_valid, ins_ready,
        output in_ready, ins, ins_valid, err_cnt
    );

endinterface

// File: rtl/adder_operand_packer.sv
// Assembles a byte stream into one s1/s2/cin operand record for the adder stage
// and holds it until the consumer takes it; counts framing errors.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no partial record; waiting for a first beat
// ST_COLLECT | fields 0..idx-1 stored; waiting for field idx
// ST_FULL    | complete record on ins, ins_valid=1, frozen until ins_ready
module adder_operand_packer
    import adder_operand_packer_pkg::*;
#(
    parameter int FIELD_W  = FIELD_W_DEF,
    parameter int N_FIELDS = N_FIELDS_DEF,
    parameter int ERR_W    = ERR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    adder_operand_packer_if.slave bus
);

    localparam int INS_W = ins_w(FIELD_W, N_FIELDS);
    localparam int IDX_W = (2 * N_FIELDS > 1) ? $clog2(2 * N_FIELDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * N_FIELDS - 1);
    localparam int CIN_BIT = N_FIELDS * FIELD_W;

    pack_state_t      state;
    logic [IDX_W-1:0] idx;
    logic [INS_W-1:0] ins_r;
    logic             ins_valid_r;
    logic [ERR_W-1:0] err_r;

    logic             accept;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic             err_evt;

    assign bus.in_ready  = (state != ST_FULL) || bus.ins_ready;
    assign bus.ins       = ins_r;
    assign bus.ins_valid = ins_valid_r;
    assign bus.err_cnt   = err_r;

    assign accept = bus.in_valid && bus.in_ready;

    // Outside COLLECT (incl. the FULL handoff cycle) only a first beat is legal.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = '0;
        err_evt = 1'b0;
        if (accept) begin
            if (state != ST_COLLECT) begin
                if (bus.in_first) begin
                    wr_en = 1'b1;
                end else begin
                    err_evt = 1'b1;
                end
            end else begin
                wr_en   = 1'b1;
                wr_idx  = bus.in_first ? '0 : idx;
                err_evt = bus.in_first;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            ins_valid_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr_en) begin
                        idx   <= IDX_W'(1);
                        state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (wr_en) begin
                        if (wr_idx == LAST_IDX) begin
                            idx         <= '0;
                            ins_valid_r <= 1'b1;
                            state       <= ST_FULL;
                        end else begin
                            idx <= wr_idx + IDX_W'(1);
                        end
                    end
                end
                ST_FULL: begin
                    if (bus.ins_ready) begin
                        ins_valid_r <= 1'b0;
                        if (wr_en) begin
                            idx   <= IDX_W'(1);
                            state <= ST_COLLECT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    idx         <= '0;
                    ins_valid_r <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins_r <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < 2 * N_FIELDS; k++) begin
                if (wr_idx == IDX_W'(k)) begin
                    ins_r[field_off(k, FIELD_W, N_FIELDS) +: FIELD_W] <= bus.in_data;
                end
            end
            if (wr_idx == LAST_IDX) begin
                ins_r[CIN_BIT] <= bus.in_cin;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= '0;
        end else if (err_evt && (err_r != {ERR_W{1'b1}})) begin
            err_r <= err_r + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_adder_operand_packer.sv
// Self-checking bench for adder_operand_packer against a queue-based record model.
module tb_adder_operand_packer;
    import adder_operand_packer_pkg::*;

    localparam int FW    = 8;
    localparam int NF    = 4;
    localparam int EW    = 8;
    localparam int IW    = 2 * NF * FW + 1;
    localparam int NBEAT = 2 * NF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    adder_operand_packer_if #(.FIELD_W(FW), .N_FIELDS(NF), .ERR_W(EW)) bus ();

    adder_operand_packer #(.FIELD_W(FW), .N_FIELDS(NF), .ERR_W(EW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model: partial record as a queue of field values
    int            part[$];
    bit            m_full = 1'b0;
    logic [IW-1:0] m_rec  = '0;
    int            m_err  = 0;

    function automatic logic [IW-1:0] pack_rec(input int f[$], input bit c);
        logic [IW-1:0] r;
        r = '0;
        for (int k = 0; k < NBEAT; k++) begin
            r = r | (IW'(f[k] & 255) << (k * FW + (k >= NF ? 1 : 0)));
        end
        r[NF * FW] = c;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit v, input bit f, input logic [FW-1:0] d, input bit c,
                         input bit rdy);
        bit m_ready;
        bus.in_valid  = v;
        bus.in_first  = f;
        bus.in_data   = d;
        bus.in_cin    = c;
        bus.ins_ready = rdy;
        #1;
        m_ready = !m_full || rdy;
        chk("in_ready", IW'(bus.in_ready), IW'(m_ready));
        @(posedge clk);
        if (m_full && rdy) m_full = 1'b0;
        if (v && m_ready) begin
            if (f) begin
                if (part.size() > 0) m_err++;
                part.delete();
                part.push_back(int'(d));
            end else if (part.size() == 0) begin
                m_err++;
            end else begin
                part.push_back(int'(d));
                if (part.size() == NBEAT) begin
                    m_rec  = pack_rec(part, c);
                    m_full = 1'b1;
                    part.delete();
                end
            end
        end
        if (m_err > 255) m_err = 255;
        #1;
        chk("ins_valid", IW'(bus.ins_valid), IW'(m_full));
        chk("err_cnt", IW'(bus.err_cnt), IW'(m_err));
        if (m_full) chk("ins", bus.ins, m_rec);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_ins", bus.ins, '0);
        chk("rst_ins_valid", IW'(bus.ins_valid), '0);
        chk("rst_err_cnt", IW'(bus.err_cnt), '0);
        part.delete();
        m_full = 1'b0;
        m_err  = 0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rst_in_ready", IW'(bus.in_ready), IW'(1));
    endtask

    task automatic send_rec(input bit c, input bit rdy);
        for (int i = 0; i < NBEAT; i++) begin
            cycle(1'b1, i == 0, FW'($urandom_range(0, 255)), (i == NBEAT - 1) ? c : 1'($urandom), rdy);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_data   = '0;
        bus.in_cin    = 1'b0;
        bus.ins_ready = 1'b0;
        #2;
        do_reset();

        // 1: directed record 01..08, cin=1
        for (int i = 0; i < NBEAT; i++) begin
            cycle(1'b1, i == 0, FW'(i + 1), i == NBEAT - 1, 1'b0);
        end
        chk("directed_ins", bus.ins, 65'h0_100E0C0B_04030201);

        // 2: hold FULL with pending beats, then handoff with a first beat
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        end
        cycle(1'b1, 1'b1, 8'h11, 1'b0, 1'b1);
        for (int i = 1; i < NBEAT; i++) begin
            cycle(1'b1, 1'b0, FW'($urandom_range(0, 255)), 1'($urandom), 1'b0);
        end
        chk("handoff_field0", IW'(bus.ins[FW-1:0]), IW'(8'h11));
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // 3: three back-to-back records, consumer always ready
        for (int r = 0; r < 3; r++) send_rec(1'($urandom), 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // 4: early restart at beat 5, then a stray beat in IDLE
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, i == 0, FW'($urandom), 1'b0, 1'b0);
        send_rec(1'b1, 1'b0);
        chk("restart_err", IW'(bus.err_cnt), IW'(1));
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 8'h5A, 1'b0, 1'b1);
        chk("stray_err", IW'(bus.err_cnt), IW'(2));

        // 5: reset mid-record and while FULL
        for (int i = 0; i < 4; i++) cycle(1'b1, i == 0, FW'($urandom), 1'b0, 1'b0);
        do_reset();
        send_rec(1'b0, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        do_reset();
        send_rec(1'b1, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // 6: saturation of the error counter
        do_reset();
        for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, FW'($urandom), 1'b0, 1'b1);
        chk("err_sat", IW'(bus.err_cnt), IW'(255));

        // random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                  FW'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
